serial_mult_arbiter: RTL and testbench

Shares one shift-add serial multiplier engine among N_REQ requesters using round-robin arbitration. Each requester presents an operand pair with a valid/ready handshake. The block sequences the engine for WIDTH cycles, then returns the product tagged with the requester ID on a single valid/ready response port. It sits between the requesting datapath clients and the serial multiplier engine.

---
 rtl/serial_mult_arbiter_pkg.sv | 14 +
 rtl/serial_mult_arbiter_mult_engine.sv | 61 ++++++
 rtl/serial_mult_arbiter.sv | 142 ++++++++++++++
 tb/tb_serial_mult_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_mult_arbiter_pkg.sv
// Shared definitions for the round-robin arbitrated serial multiplier.
package serial_mult_arbiter_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_N_REQ = 4;

  // Arbiter FSM encoding; also exported on the debug state port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/serial_mult_arbiter_mult_engine.sv
// Shift-add unsigned multiplier. A load captures the operands and clears the
// accumulator; WIDTH edges later the product is complete. done is high in the
// cycle whose closing edge performs the final step, and product carries the
// value the accumulator takes on that edge, so the caller can capture it then.
module mult_engine
  import serial_mult_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] a_shift_q;
  logic [WIDTH-1:0]   b_shift_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   count_q;
  logic [2*WIDTH-1:0] acc_next;

  // Accumulator value after the current step (adds a_shift when b's LSB is set).
  always_comb begin
    acc_next = acc_q;
    if (b_shift_q[0]) begin
      acc_next = acc_q + a_shift_q;
    end
  end

  // Load operands, then one shift-add step per edge while count is nonzero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_shift_q <= '0;
      b_shift_q <= '0;
      acc_q     <= '0;
      count_q   <= '0;
    end else if (load) begin
      a_shift_q <= {{WIDTH{1'b0}}, a};
      b_shift_q <= b;
      acc_q     <= '0;
      count_q   <= CNT_W'(WIDTH);
    end else if (count_q != '0) begin
      acc_q     <= acc_next;
      a_shift_q <= a_shift_q << 1;
      b_shift_q <= b_shift_q >> 1;
      count_q   <= count_q - CNT_W'(1);
    end
  end

  // Final step is the one taken while count is 1.
  always_comb begin
    done    = (count_q == CNT_W'(1));
    product = acc_next;
  end

endmodule

// File: rtl/serial_mult_arbiter.sv
// Round-robin arbiter sharing one serial multiplier among N_REQ requesters.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Requesters hold valid and operands until ready; ready never
// depends on anything but arbiter state and req_valid. The response port holds
// rsp_valid/rsp_id/rsp_product stable until rsp_ready is seen high.
module serial_mult_arbiter
  import serial_mult_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]     rsp_product,
  output logic                   busy,
  output state_t                 dbg_state
);

  state_t             state_q;
  state_t             state_d;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [2*WIDTH-1:0] rsp_product_q;
  logic               rsp_valid_q;

  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic               accept;
  logic               eng_done;
  logic [2*WIDTH-1:0] eng_product;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % N_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == grant_idx) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  mult_engine #(
    .WIDTH (WIDTH)
  ) u_engine (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .a       (a_sel),
    .b       (b_sel),
    .done    (eng_done),
    .product (eng_product)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_RUN;
      ST_RUN:  if (eng_done)  state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: grant is offered only while idle.
  always_comb begin
    req_ready = '0;
    accept    = (state_q == ST_IDLE) && grant_found;
    busy      = (state_q != ST_IDLE);
    dbg_state = state_q;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Pointer, owner tag and response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
      rsp_valid_q   <= 1'b0;
    end else begin
      if (accept) begin
        rsp_id_q <= grant_idx;
        rr_ptr_q <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      end
      if (state_q == ST_RUN && eng_done) begin
        rsp_product_q <= eng_product;
        rsp_valid_q   <= 1'b1;
      end
      if (state_q == ST_RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  // Response port drives straight from the registers.
  always_comb begin
    rsp_valid   = rsp_valid_q;
    rsp_id      = rsp_id_q;
    rsp_product = rsp_product_q;
  end

endmodule

// File: tb/tb_serial_mult_arbiter.sv
// Directed bench for serial_mult_arbiter (N_REQ=4, WIDTH=4).
module tb_serial_mult_arbiter;
  import serial_mult_arbiter_pkg::*;

  localparam int N_REQ = 4;
  localparam int WIDTH = 4;
  localparam int ID_W  = 2;
  localparam int LAT   = WIDTH + 1;

  logic                   clk;
  logic                   rst_n;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [2*WIDTH-1:0]     rsp_product;
  logic                   busy;
  state_t                 dbg_state;

  logic [WIDTH-1:0] op_a [N_REQ];
  logic [WIDTH-1:0] op_b [N_REQ];

  logic [ID_W+2*WIDTH-1:0] exp_q [$];

  int n_total;
  int n_pass;

  serial_mult_arbiter #(
    .N_REQ (N_REQ),
    .WIDTH (WIDTH),
    .ID_W  (ID_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = op_a[i];
      req_b[i*WIDTH +: WIDTH] = op_b[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int onehot_idx(input logic [N_REQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N_REQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Scoreboard pop and compare for one response
  task automatic score_rsp(input string tag);
    logic [ID_W+2*WIDTH-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_rsp"}, 32'(rsp_valid), 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_id"}, 32'(rsp_id), 32'(e[ID_W+2*WIDTH-1:2*WIDTH]));
      check({tag, "_product"}, 32'(rsp_product), 32'(e[2*WIDTH-1:0]));
    end
  endtask

  // Driver: one operation from mask, expecting grant exp_g and product exp_prod.
  task automatic run_op(input string tag, input logic [N_REQ-1:0] mask,
                        input int exp_g, input logic [2*WIDTH-1:0] exp_prod);
    int lat;
    @(negedge clk);
    req_valid = mask;
    rsp_ready = 1'b1;
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(1) << exp_g);
    exp_q.push_back({ID_W'(exp_g), exp_prod});
    @(negedge clk);
    req_valid = '0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    score_rsp(tag);
    @(negedge clk);
    #1;
    check({tag, "_one_cycle"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int grants, rsps, cyc, g, lat, seen;
    int order [5];
    logic [2*WIDTH-1:0] exp_tab [N_REQ];
    n_total = 0;
    n_pass  = 0;
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_product", 32'(rsp_product), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Single request and boundary operands
    op_a[2] = 4'd13; op_b[2] = 4'd11;
    run_op("single_r2", 4'b0100, 2, 8'd143);
    op_a[0] = 4'd0;  op_b[0] = 4'd15;
    run_op("zero", 4'b0001, 0, 8'd0);
    op_a[3] = 4'd15; op_b[3] = 4'd15;
    run_op("max", 4'b1000, 3, 8'd225);
    op_a[1] = 4'd1;  op_b[1] = 4'd1;
    run_op("one", 4'b0010, 1, 8'd1);

    // All requesters continuously valid
    do_reset();
    op_a[0] = 4'd3;  op_b[0] = 4'd5;  exp_tab[0] = 8'd15;
    op_a[1] = 4'd9;  op_b[1] = 4'd2;  exp_tab[1] = 8'd18;
    op_a[2] = 4'd14; op_b[2] = 4'd12; exp_tab[2] = 8'd168;
    op_a[3] = 4'd11; op_b[3] = 4'd7;  exp_tab[3] = 8'd77;
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    @(negedge clk);
    req_valid = 4'hF;
    grants = 0; rsps = 0; cyc = 0;
    while (rsps < 5 && cyc < 100) begin
      #1;
      check("cont_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      if (rsp_valid) begin
        score_rsp("cont");
        rsps++;
      end
      if (req_ready != '0 && grants < 5) begin
        g = onehot_idx(req_ready);
        check("cont_grant_order", 32'(g), 32'(order[grants]));
        exp_q.push_back({ID_W'(g), exp_tab[g]});
        grants++;
      end
      @(negedge clk);
      cyc++;
      if (grants == 5) req_valid = '0;
    end
    check("cont_rsp_count", 32'(rsps), 32'd5);
    exp_q.delete();

    // Backpressure on the response port
    do_reset();
    op_a[0] = 4'd7; op_b[0] = 4'd9;
    op_a[1] = 4'd2; op_b[1] = 4'd3;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0010;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", 32'(lat), 32'(LAT));
    for (int k = 0; k < 7; k++) begin
      #1;
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_id", 32'(rsp_id), 32'd0);
      check("bp_product", 32'(rsp_product), 32'd63);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_hs_req_ready", 32'(req_ready), 32'd0);
    check("bp_hs_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    #1;
    check("bp_after_valid", 32'(rsp_valid), 32'd0);
    check("bp_after_grant", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = '0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_r1_latency", 32'(lat), 32'(LAT));
    check("bp_r1_id", 32'(rsp_id), 32'd1);
    check("bp_r1_product", 32'(rsp_product), 32'd6);

    // Reset in the middle of RUN
    do_reset();
    op_a[2] = 4'd5; op_b[2] = 4'd5;
    @(negedge clk);
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #2;
    check("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_id", 32'(rsp_id), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("mid_no_rsp", 32'(seen), 32'd0);
    op_a[3] = 4'd6; op_b[3] = 4'd7;
    run_op("mid_r3", 4'b1000, 3, 8'd42);

    // Pointer fairness: three ops from requester 1, then 0 and 1 compete
    do_reset();
    op_a[1] = 4'd2; op_b[1] = 4'd7;
    run_op("fair_a", 4'b0010, 1, 8'd14);
    run_op("fair_b", 4'b0010, 1, 8'd14);
    run_op("fair_c", 4'b0010, 1, 8'd14);
    op_a[0] = 4'd6; op_b[0] = 4'd5;
    run_op("fair_wrap", 4'b0011, 0, 8'd30);
    run_op("fair_next", 4'b0011, 1, 8'd14);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
